// File: rtl/bch_encoder.sv
// bch_encoder: serial BCH(31,16) systematic encoder producing {message, parity} in 16 LFSR steps.
module bch_encoder #(
    parameter logic [15:0] GEN_POLY = 16'h8FAF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic        readready,
    output logic        busy,
    output logic        outready,
    output logic [30:0] outdata
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] msg_q, msg_d, shift_q, shift_d;
    logic [14:0] rem_q, rem_d, rem_step;
    logic [3:0]  cnt_q, cnt_d;
    logic [30:0] out_q, out_d;
    logic        rdy_q, rdy_d;
    logic        fb;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE)  ? (readready ? SHIFT : IDLE) :
                  (state_q == SHIFT) ? ((cnt_q == 4'd0) ? DONE : SHIFT) : IDLE;
    end
    always_comb begin
        busy = (state_q != IDLE);
    end
    // one MSB-first division step of the message stream by g(x)
    assign fb       = shift_q[15] ^ rem_q[14];
    assign rem_step = {rem_q[13:0], 1'b0} ^ (fb ? GEN_POLY[14:0] : 15'h0);
    always_comb begin
        msg_d   = msg_q;
        shift_d = shift_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rdy_d   = rdy_q;
        if (state_q == IDLE && readready) begin
            msg_d   = data;
            shift_d = data;
            rem_d   = '0;
            cnt_d   = 4'd15;
        end else if (state_q == SHIFT) begin
            shift_d = shift_q << 1;
            rem_d   = rem_step;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q == 4'd0) begin
                out_d = {msg_q, rem_step};
                rdy_d = 1'b1;
            end
        end else if (state_q == DONE) begin
            rdy_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_q   <= '0;
            shift_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            msg_q   <= msg_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rdy_q   <= rdy_d;
        end
    end
    assign outready = rdy_q;
    assign outdata  = out_q;
endmodule

// File: doc/bch_encoder.md
BCH_ENCODER -- requirements
Module: bch_encoder

Interface
REQ-001 Parameter GEN_POLY, default 16'h8FAF, is the BCH(31,16) generator g(x)=x^15+x^11+x^10+x^9+x^8+x^7+x^5+x^3+x^2+x+1; bit 15 is implicit and unused.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 data  input  16  message word; bit 15 is the highest-order message coefficient (x^30 of the codeword).
REQ-005 readready  input  1  request strobe; data is valid in the same cycle.
REQ-006 busy  output  1  high while an encode is in progress (states SHIFT and DONE).
REQ-007 outready  output  1  one-cycle pulse; outdata is valid from this cycle on.
REQ-008 outdata  output  31  systematic codeword {message[15:0], parity[14:0]}; this is the input format of the downstream BCH decoder.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-010 In IDLE with readready=1, the block SHALL, on the edge:
- latch data into msg_reg and shift_reg;
- clear the 15-bit remainder rem to 0;
- load the bit counter cnt with 15;
- move to SHIFT.
REQ-011 In IDLE with readready=0, the block SHALL hold all registers.
REQ-012 Each SHIFT edge SHALL perform one LFSR step, MSB first:
- fb = shift_reg[15] ^ rem[14];
- rem <= {rem[13:0],1'b0} ^ (fb ? GEN_POLY[14:0] : 15'h0);
- shift_reg <= shift_reg << 1;
- cnt <= cnt - 1.
REQ-013 On the SHIFT edge where cnt==0, the block SHALL:
- perform the final step;
- write outdata <= {msg_reg, next rem};
- set outready <= 1;
- move to DONE.
REQ-014 The SHIFT state SHALL last exactly 16 edges; outready SHALL rise on the 16th edge after the accepting edge.
REQ-015 In DONE, the block SHALL clear outready and return to IDLE on the next edge; the minimum request-to-request spacing is 18 cycles.
REQ-016 readready SHALL be ignored in SHIFT and DONE; no queuing, and msg_reg, outdata and the encode in progress are unaffected.
REQ-017 outdata SHALL hold its last codeword until the next completed encode overwrites it.
REQ-018 busy SHALL be combinational: busy = (state != IDLE).
REQ-019 The parity SHALL equal (m(x)*x^15) mod g(x) over GF(2); the block is linear, so encode(a^b) = encode(a) ^ encode(b).

Reset
REQ-020 Asserting reset SHALL immediately force:
- state=IDLE;
- outready=0, outdata=0;
- rem=0, cnt=0, msg_reg=0, shift_reg=0.
REQ-021 Reset asserted mid-encode SHALL abort it with no outready pulse; the first request after reset deassertion SHALL be accepted normally.
REQ-022 A request present in the first edge after reset deassertion SHALL be accepted.

Verification
REQ-023 data=16'h0000, readready pulse -> outready pulse 16 edges later, outdata=31'h00000000.
REQ-024 data=16'h0001 -> outdata=31'h00008FAF (parity 15'h0FAF).
REQ-025 data=16'h0003 -> outdata=31'h000190F1. data=16'hFFFF -> outdata=31'h7FFFFFFF.
REQ-026 Request 16'h0001 followed by readready=1 held with data=16'hFFFF during SHIFT/DONE:
- exactly one outready pulse, with outdata=31'h00008FAF;
- data=16'hFFFF accepted on the first IDLE cycle -> 31'h7FFFFFFF 16 edges later.
REQ-027 Reset pulsed 8 cycles into an encode -> no outready, outdata=0, busy=0; a following request for 16'h0003 -> 31'h000190F1.
REQ-028 Random sweep of 1000 messages against a reference model:
- the 31-bit codeword mod g(x) is 0;
- outready is high for exactly one cycle per accepted request.
